// File: rtl/score_keeper.sv
// Score keeper and serve/pause/game-over controller downstream of the ball mover.
// Optional feature: define PONG_SCORE_BCD_EN for 2-digit packed BCD scores (binary otherwise).
module score_keeper #(
    parameter int unsigned DISP_COLS      = 800,
    parameter int unsigned LEFT_GOAL_COL  = 4,
    parameter int unsigned RIGHT_GOAL_COL = DISP_COLS - 4,
    parameter int unsigned WIN_SCORE      = 11,
    parameter int unsigned PAUSE_CYCLES   = 50000000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] ball_center_col,
    input  logic        start,
    output logic [7:0]  l_score,
    output logic [7:0]  r_score,
    output logic        ball_hold,
    output logic [1:0]  serve_dir,
    output logic        game_over,
    output logic        winner
);

    localparam int unsigned COL_W   = 12;
    localparam int unsigned SCORE_W = 8;

`ifdef PONG_SCORE_BCD_EN
    localparam logic [SCORE_W-1:0] WIN_VAL =
        SCORE_W'(((WIN_SCORE / 10) * 16) + (WIN_SCORE % 10));
`else
    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 start_q;
    logic [SCORE_W-1:0]   l_q, l_d, r_q, r_d;
    logic                 hold_q, hold_d;
    logic [1:0]           dir_q, dir_d;
    logic                 over_q, over_d;
    logic                 win_q, win_d;

    logic start_rise;
    logic left_goal;
    logic right_goal;
    logic pause_done;
    logic someone_won;

    assign start_rise  = start & ~start_q;
    assign left_goal   = ball_center_col <= COL_W'(LEFT_GOAL_COL);
    assign right_goal  = ball_center_col >= COL_W'(RIGHT_GOAL_COL);
    assign pause_done  = cnt_q == CNT_W'(PAUSE_CYCLES - 1);
    assign someone_won = (l_q == WIN_VAL) || (r_q == WIN_VAL);

    // Saturating score increment in the configured encoding.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        if (s == WIN_VAL) begin
            return s;
        end
`ifdef PONG_SCORE_BCD_EN
        if (s[3:0] == 4'd9) begin
            return {s[7:4] + 4'd1, 4'd0};
        end
        return {s[7:4], s[3:0] + 4'd1};
`else
        return s + SCORE_W'(1);
`endif
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            l_q     <= '0;
            r_q     <= '0;
            hold_q  <= 1'b1;
            dir_q   <= 2'b00;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start;
            l_q     <= l_d;
            r_q     <= r_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            over_q  <= over_d;
            win_q   <= win_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_rise) state_d = PAUSE;
            PLAY:    if (left_goal || right_goal) state_d = PAUSE;
            PAUSE:   if (pause_done) state_d = someone_won ? OVER : PLAY;
            OVER:    if (start_rise) state_d = PAUSE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; left goal takes priority on a tie.
    always_comb begin
        cnt_d  = '0;
        l_d    = l_q;
        r_d    = r_q;
        dir_d  = dir_q;
        win_d  = win_q;
        case (state_q)
            PLAY: begin
                if (left_goal) begin
                    r_d   = score_inc(r_q);
                    dir_d = 2'b10;
                end else if (right_goal) begin
                    l_d   = score_inc(l_q);
                    dir_d = 2'b01;
                end
            end
            PAUSE: begin
                if (!pause_done) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (someone_won) begin
                    win_d = (r_q == WIN_VAL);
                end
            end
            OVER: begin
                if (start_rise) begin
                    l_d   = '0;
                    r_d   = '0;
                    dir_d = 2'b00;
                end
            end
            default: ;
        endcase
        hold_d = (state_d != PLAY);
        over_d = (state_d == OVER);
    end

    assign l_score   = l_q;
    assign r_score   = r_q;
    assign ball_hold = hold_q;
    assign serve_dir = dir_q;
    assign game_over = over_q;
    assign winner    = win_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a short pause (PAUSE_CYCLES=4).
module tb_score_keeper;

    logic        clk;
    logic        rst_n;
    logic [11:0] ball_center_col;
    logic        start;
    logic [7:0]  l_score;
    logic [7:0]  r_score;
    logic        ball_hold;
    logic [1:0]  serve_dir;
    logic        game_over;
    logic        winner;

    int total = 0;
    int bad   = 0;

    localparam logic [11:0] MID_COL   = 12'd400;
    localparam logic [11:0] LEFT_COL  = 12'd3;
    localparam logic [11:0] RIGHT_COL = 12'd796;

    score_keeper #(
        .PAUSE_CYCLES (4),
        .CNT_W        (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ball_center_col (ball_center_col),
        .start           (start),
        .l_score         (l_score),
        .r_score         (r_score),
        .ball_hold       (ball_hold),
        .serve_dir       (serve_dir),
        .game_over       (game_over),
        .winner          (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sc(input int n);
`ifdef PONG_SCORE_BCD_EN
        return 8'(((n / 10) * 16) + (n % 10));
`else
        return 8'(n);
`endif
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_play(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ball_hold === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        ball_center_col = MID_COL;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        total++; if (ball_hold !== 1'b1) begin bad++; $display("FAIL reset_hold got=%b exp=1", ball_hold); end
        total++; if (l_score !== 8'd0) begin bad++; $display("FAIL reset_l got=%h exp=00", l_score); end
        total++; if (r_score !== 8'd0) begin bad++; $display("FAIL reset_r got=%h exp=00", r_score); end
        total++; if (serve_dir !== 2'b00) begin bad++; $display("FAIL reset_dir got=%b exp=00", serve_dir); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_over got=%b exp=0", game_over); end
        total++; if (winner !== 1'b0) begin bad++; $display("FAIL reset_winner got=%b exp=0", winner); end
    endtask

    task automatic test_start_serve();
        int fall = 0;
        start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (fall == 0 && ball_hold === 1'b0) fall = i;
        end
        total++; if (fall != 5) begin bad++; $display("FAIL serve_latency got=%0d exp=5", fall); end
        start = 1'b0;
        tick(3);
        total++; if (ball_hold !== 1'b0) begin bad++; $display("FAIL serve_single_start got=%b exp=0", ball_hold); end
    endtask

    task automatic test_left_goal();
        ball_center_col = LEFT_COL;
        tick();
        total++; if (r_score !== sc(1)) begin bad++; $display("FAIL lgoal_r got=%h exp=%h", r_score, sc(1)); end
        total++; if (l_score !== sc(0)) begin bad++; $display("FAIL lgoal_l got=%h exp=%h", l_score, sc(0)); end
        total++; if (serve_dir !== 2'b10) begin bad++; $display("FAIL lgoal_dir got=%b exp=10", serve_dir); end
        total++; if (ball_hold !== 1'b1) begin bad++; $display("FAIL lgoal_hold got=%b exp=1", ball_hold); end
        tick(4);
        ball_center_col = MID_COL;
        tick(3);
        total++; if (r_score !== sc(1)) begin bad++; $display("FAIL lgoal_once got=%h exp=%h", r_score, sc(1)); end
        total++; if (ball_hold !== 1'b0) begin bad++; $display("FAIL lgoal_replay got=%b exp=0", ball_hold); end
    endtask

    task automatic test_carry();
        bit ok;
        for (int g = 1; g <= 10; g++) begin
            wait_play(ok);
            total++; if (!ok) begin bad++; $display("FAIL carry_wait_play goal=%0d got=timeout exp=play", g); end
            ball_center_col = RIGHT_COL;
            tick();
            ball_center_col = MID_COL;
            if (g == 9) begin
                total++; if (l_score !== sc(9)) begin bad++; $display("FAIL carry_nine got=%h exp=%h", l_score, sc(9)); end
            end
        end
        total++; if (l_score !== sc(10)) begin bad++; $display("FAIL carry_ten got=%h exp=%h", l_score, sc(10)); end
        total++; if (r_score !== sc(1)) begin bad++; $display("FAIL carry_r got=%h exp=%h", r_score, sc(1)); end
        total++; if (serve_dir !== 2'b01) begin bad++; $display("FAIL carry_dir got=%b exp=01", serve_dir); end
    endtask

    task automatic test_game_over();
        bit ok;
        wait_play(ok);
        total++; if (!ok) begin bad++; $display("FAIL over_wait_play got=timeout exp=play"); end
        ball_center_col = RIGHT_COL;
        tick();
        ball_center_col = MID_COL;
        total++; if (l_score !== sc(11)) begin bad++; $display("FAIL over_l got=%h exp=%h", l_score, sc(11)); end
        tick(3);
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL over_early got=%b exp=0", game_over); end
        tick();
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL over_flag got=%b exp=1", game_over); end
        total++; if (winner !== 1'b0) begin bad++; $display("FAIL over_winner got=%b exp=0", winner); end
        total++; if (ball_hold !== 1'b1) begin bad++; $display("FAIL over_hold got=%b exp=1", ball_hold); end
        ball_center_col = LEFT_COL;
        tick(3);
        ball_center_col = MID_COL;
        total++; if (r_score !== sc(1)) begin bad++; $display("FAIL over_ignore_r got=%h exp=%h", r_score, sc(1)); end
        total++; if (l_score !== sc(11)) begin bad++; $display("FAIL over_ignore_l got=%h exp=%h", l_score, sc(11)); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (l_score !== 8'd0 || r_score !== 8'd0) begin bad++; $display("FAIL restart_scores got=%h/%h exp=00/00", l_score, r_score); end
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL restart_over got=%b exp=0", game_over); end
        total++; if (serve_dir !== 2'b00) begin bad++; $display("FAIL restart_dir got=%b exp=00", serve_dir); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        total++; if (ball_hold !== 1'b1) begin bad++; $display("FAIL restart_pause got=%b exp=1", ball_hold); end
        tick();
        total++; if (ball_hold !== 1'b0) begin bad++; $display("FAIL restart_play got=%b exp=0", ball_hold); end
    endtask

    task automatic test_async_reset();
        ball_center_col = LEFT_COL;
        tick();
        ball_center_col = MID_COL;
        total++; if (r_score !== sc(1)) begin bad++; $display("FAIL areset_pre_r got=%h exp=%h", r_score, sc(1)); end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (r_score !== 8'd0) begin bad++; $display("FAIL areset_r got=%h exp=00", r_score); end
        total++; if (serve_dir !== 2'b00) begin bad++; $display("FAIL areset_dir got=%b exp=00", serve_dir); end
        total++; if (ball_hold !== 1'b1) begin bad++; $display("FAIL areset_hold got=%b exp=1", ball_hold); end
        total++; if (game_over !== 1'b0 || winner !== 1'b0) begin bad++; $display("FAIL areset_over got=%b%b exp=00", game_over, winner); end
        tick();
        rst_n = 1'b1;
        tick(8);
        total++; if (ball_hold !== 1'b1) begin bad++; $display("FAIL areset_idle got=%b exp=1", ball_hold); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ball_center_col = MID_COL;
        test_reset();
        test_start_serve();
        test_left_goal();
        test_carry();
        test_game_over();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
